nand_flash_page_writer: RTL and testbench
=========================================

# nand_flash_page_writer

Host-side NAND flash page programmer, the write-direction companion to the existing flash read path on the same F_*_A pins. On a start request it issues the page-program sequence (0x80, four address cycles, one page of data, 0x10), waits out the busy period on R/B#, then reads status (0x70) and reports pass/fail. Write data arrives as a valid/ready byte stream. The IO bus is split into drive, output-enable and sample signals, and the tristate buffer sits at the top level.

## Interface
- PAGE_BYTES, 512: data bytes per program operation.
- ROW_W, 17: page (row) address width; must be at most 24.
- WE_LOW, 1: clocks that F_WEN_A is held low per write cycle; must be at least 1.
- WE_HIGH, 1: clocks that F_WEN_A is held high after each pulse; must be at least 1.
- RE_LOW, 2: clocks that F_REN_A is held low for the status read; must be at least 1.
- TWB, 4: clocks to wait after 0x10 before R/B# is sampled.
- BUSY_TO, 200000: maximum clocks to wait for R/B# to return high.
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- start  in  1  one-clock request; accepted only while busy=0.
- row_addr  in  ROW_W  page address; captured when start is accepted.
- wr_data  in  8  page data byte.
- wr_valid  in  1  wr_data is valid.
- wr_ready  out  1  byte accepted this clock when wr_valid=1.
- busy  out  1  operation in progress.
- done  out  1  one-clock pulse at the end of every operation.
- fail  out  1  result of the last operation; valid when done=1 and held until the next start.
- timeout  out  1  last operation ended on BUSY_TO; held until the next start.
- F_CEN_A  out  1  chip enable, active low.
- F_CLE_A  out  1  command latch enable.
- F_ALE_A  out  1  address latch enable.
- F_WEN_A  out  1  write enable, active low.
- F_REN_A  out  1  read enable, active low.
- F_RB_A  in  1  ready/busy#; asynchronous, passed through a 2-FF synchronizer.
- io_o  out  8  IO drive value.
- io_oe  out  1  IO output enable.
- io_i  in  8  IO sample value.

## Operation
- Reset values: F_CEN_A=1, F_CLE_A=0, F_ALE_A=0, F_WEN_A=1, F_REN_A=1, io_o=0, io_oe=0, busy=0, done=0, fail=0, timeout=0, wr_ready=0. The FSM returns to IDLE.
- States and transitions: IDLE → CMD80 → ADDR(x4) → DATA(xPAGE_BYTES) → CMD10 → TWB → WAIT_RB → CMD70 → RD_STAT → DONE → IDLE.
- Write bus cycle (used for every command, address and data byte):
  - 1 setup clock: io_o, io_oe=1 and CLE/ALE driven, F_WEN_A=1.
  - WE_LOW clocks with F_WEN_A=0.
  - WE_HIGH clocks with F_WEN_A=1; io_o, CLE and ALE are held.
- Address bytes, in order: 0x00 (column 0), row[7:0], row[15:8], then row[23:16] zero-padded above ROW_W.
- DATA handshake:
  - wr_ready=1 only during a DATA setup clock.
  - A byte transfers on wr_ready & wr_valid and is driven on io_o.
  - If wr_valid=0 the FSM stalls in setup with F_WEN_A=1, for any number of clocks.
  - An internal byte counter (clog2(PAGE_BYTES)+1 bits) is compared against PAGE_BYTES; exactly PAGE_BYTES transfers occur.
- TWB: io_oe=0 and a counter runs for TWB clocks.
- WAIT_RB:
  - Leaves when synchronized R/B#=1.
  - Exceeding BUSY_TO clocks sets timeout=1 and fail=1, skips CMD70/RD_STAT, and goes to DONE.
- RD_STAT: io_oe=0, F_REN_A=0 for RE_LOW clocks; io_i is sampled on the last low clock and fail=io_i[0]. F_REN_A then returns high for 1 clock.
- DONE: done=1 for one clock, F_CEN_A=1, busy=0 on the next clock.
- busy=1 from the clock after start is accepted through DONE. start while busy=1 is ignored.
- Asynchronous rst mid-operation aborts immediately to reset values. The device is left mid-program; recovery is the caller's responsibility.

## Timing
- start accepted at clock 0 → F_CEN_A=0 and CMD80 setup at clock 1.
- Each write bus cycle lasts 1+WE_LOW+WE_HIGH clocks (3 at defaults). Command, address and data each use one such cycle.
- With no stalls, at defaults, the first data byte's setup clock is clock 1 + 5×3 = 16.
- R/B# synchronizer adds 2 clocks of latency to busy detection.
- fail, timeout and done are registered outputs; no combinational path from F_IO inputs to any output.

## Structure
- Package nand_pkg holds:
  - Command constants: CMD_PROG=8'h80, CMD_CONFIRM=8'h10, CMD_STATUS=8'h70.
  - FSM state enum.
  - STATUS_FAIL_BIT=0.
- One sub-module, nand_bus_cycle:
  - Takes go, byte, cle and ale.
  - Produces the setup/WE_LOW/WE_HIGH sequence and a last pulse.
  - Reusable by the read path.

## Test plan
- Basic program: row_addr=17'h1_2345, bytes 0..255 twice, R/B# low 50 clocks; model returns status 0x00 → bus captures 80, 00, 45, 23, 01, 512 data bytes, 10, 70; done pulse; fail=0.
- Backpressure: wr_valid toggles every 3 clocks → F_WEN_A never falls during a stall, exactly 512 bytes are captured in order, and no bytes are duplicated.
- Program failure: model returns status 0x01 → fail=1 at done; fail and timeout are cleared by the next start.
- Timeout: R/B# held low, BUSY_TO=100 → timeout=1, fail=1, no 0x70 issued, done about 100 clocks after TWB ends.
- start while busy: second start mid-DATA is ignored → byte count and row address are unchanged.
- Reset mid-DATA at byte 37 → all outputs take reset values within 1 clock; a following normal program completes correctly.

Source files
------------

// File: rtl/nand_pkg.sv
// Shared constants, FSM state encoding and address helper for the NAND flash host blocks.
package nand_pkg;

  localparam logic [7:0] CMD_PROG    = 8'h80;
  localparam logic [7:0] CMD_CONFIRM = 8'h10;
  localparam logic [7:0] CMD_STATUS  = 8'h70;

  localparam int unsigned STATUS_FAIL_BIT = 0;

  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_CMD80   = 4'd1,
    S_ADDR    = 4'd2,
    S_DATA    = 4'd3,
    S_CMD10   = 4'd4,
    S_TWB     = 4'd5,
    S_WAIT_RB = 4'd6,
    S_CMD70   = 4'd7,
    S_RD_STAT = 4'd8,
    S_DONE    = 4'd9
  } state_t;

  // Address cycle order: column 0, then the row LSB first.
  function automatic logic [7:0] addr_byte(input logic [23:0] row, input logic [1:0] idx);
    case (idx)
      2'd0:    return 8'h00;
      2'd1:    return row[7:0];
      2'd2:    return row[15:8];
      default: return row[23:16];
    endcase
  endfunction

endpackage

// File: rtl/nand_bus_cycle.sv
// One NAND write bus cycle: setup clock, WE_LOW clocks of WE# low, WE_HIGH clocks high.
// A go on the last clock chains the next cycle with no idle gap.
module nand_bus_cycle #(
  parameter int unsigned WE_LOW  = 1,
  parameter int unsigned WE_HIGH = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       go_i,
  input  logic       hold_i,
  input  logic [7:0] byte_i,
  input  logic       cle_i,
  input  logic       ale_i,
  output logic [7:0] io_o,
  output logic       cle_o,
  output logic       ale_o,
  output logic       wen_o,
  output logic       active_o,
  output logic       setup_o,
  output logic       last_o
);

  localparam logic [1:0] P_IDLE  = 2'd0;
  localparam logic [1:0] P_SETUP = 2'd1;
  localparam logic [1:0] P_LOW   = 2'd2;
  localparam logic [1:0] P_HIGH  = 2'd3;
  localparam int unsigned CMAX = (WE_LOW > WE_HIGH) ? WE_LOW : WE_HIGH;
  localparam int unsigned CW   = $clog2(CMAX + 1);

  logic [1:0]    phase_q, phase_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [7:0]    io_q, io_d;
  logic          cle_q, cle_d;
  logic          ale_q, ale_d;

  assign last_o   = (phase_q == P_HIGH) && (cnt_q == CW'(WE_HIGH - 1));
  assign setup_o  = (phase_q == P_SETUP);
  assign active_o = (phase_q != P_IDLE);
  assign wen_o    = (phase_q != P_LOW);
  assign io_o     = io_q;
  assign cle_o    = cle_q;
  assign ale_o    = ale_q;

  always_comb begin
    phase_d = phase_q;
    cnt_d   = cnt_q;
    io_d    = io_q;
    cle_d   = cle_q;
    ale_d   = ale_q;
    case (phase_q)
      P_IDLE: begin
        if (go_i) begin
          phase_d = P_SETUP;
          io_d    = byte_i;
          cle_d   = cle_i;
          ale_d   = ale_i;
        end
      end
      P_SETUP: begin
        // Byte is re-latched as setup ends so a stalled data stream lands its accepted byte.
        if (!hold_i) begin
          phase_d = P_LOW;
          cnt_d   = '0;
          io_d    = byte_i;
        end
      end
      P_LOW: begin
        if (cnt_q == CW'(WE_LOW - 1)) begin
          phase_d = P_HIGH;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        if (last_o) begin
          if (go_i) begin
            phase_d = P_SETUP;
            io_d    = byte_i;
            cle_d   = cle_i;
            ale_d   = ale_i;
          end else begin
            phase_d = P_IDLE;
            cle_d   = 1'b0;
            ale_d   = 1'b0;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase_q <= P_IDLE;
      cnt_q   <= '0;
      io_q    <= '0;
      cle_q   <= 1'b0;
      ale_q   <= 1'b0;
    end else begin
      phase_q <= phase_d;
      cnt_q   <= cnt_d;
      io_q    <= io_d;
      cle_q   <= cle_d;
      ale_q   <= ale_d;
    end
  end

endmodule

// File: rtl/nand_flash_page_writer.sv
// NAND page program sequencer: 0x80, four address cycles, one page of streamed data,
// 0x10, R/B# wait with timeout, then 0x70 status read to report pass/fail.
module nand_flash_page_writer
  import nand_pkg::*;
#(
  parameter int unsigned PAGE_BYTES = 512,
  parameter int unsigned ROW_W      = 17,
  parameter int unsigned WE_LOW     = 1,
  parameter int unsigned WE_HIGH    = 1,
  parameter int unsigned RE_LOW     = 2,
  parameter int unsigned TWB        = 4,
  parameter int unsigned BUSY_TO    = 200000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [ROW_W-1:0] row_addr,
  input  logic [7:0]       wr_data,
  input  logic             wr_valid,
  output logic             wr_ready,
  output logic             busy,
  output logic             done,
  output logic             fail,
  output logic             timeout,
  output logic             F_CEN_A,
  output logic             F_CLE_A,
  output logic             F_ALE_A,
  output logic             F_WEN_A,
  output logic             F_REN_A,
  input  logic             F_RB_A,
  output logic [7:0]       io_o,
  output logic             io_oe,
  input  logic [7:0]       io_i
);

  localparam int unsigned BCW = $clog2(PAGE_BYTES) + 1;
  localparam int unsigned TW  = $clog2(BUSY_TO + TWB + RE_LOW + 1) + 1;

  state_t           state_q, state_d;
  logic [ROW_W-1:0] row_q, row_d;
  logic [1:0]       aidx_q, aidx_d;
  logic [BCW-1:0]   bcnt_q, bcnt_d;
  logic [TW-1:0]    tmr_q, tmr_d;
  logic             fail_q, fail_d;
  logic             to_q, to_d;
  logic             rb_meta_q, rb_sync_q;

  logic [23:0] row24;
  logic        go, hold, bcle, bale, bus_setup, bus_last;
  logic [7:0]  bbyte;

  assign row24    = 24'(row_q);
  assign hold     = (state_q == S_DATA) && !wr_valid;
  assign wr_ready = (state_q == S_DATA) && bus_setup;
  assign busy     = (state_q != S_IDLE);
  assign done     = (state_q == S_DONE);
  assign fail     = fail_q;
  assign timeout  = to_q;
  assign F_CEN_A  = (state_q == S_IDLE) || (state_q == S_DONE);
  assign F_REN_A  = !((state_q == S_RD_STAT) && (tmr_q < TW'(RE_LOW)));

  nand_bus_cycle #(
    .WE_LOW (WE_LOW),
    .WE_HIGH(WE_HIGH)
  ) u_bus (
    .clk     (clk),
    .rst     (rst),
    .go_i    (go),
    .hold_i  (hold),
    .byte_i  (bbyte),
    .cle_i   (bcle),
    .ale_i   (bale),
    .io_o    (io_o),
    .cle_o   (F_CLE_A),
    .ale_o   (F_ALE_A),
    .wen_o   (F_WEN_A),
    .active_o(io_oe),
    .setup_o (bus_setup),
    .last_o  (bus_last)
  );

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    aidx_d  = aidx_q;
    bcnt_d  = bcnt_q;
    tmr_d   = tmr_q;
    fail_d  = fail_q;
    to_d    = to_q;
    go      = 1'b0;
    bcle    = 1'b0;
    bale    = 1'b0;
    // Byte of the cycle in progress; overridden below with the next cycle's byte on go.
    case (state_q)
      S_CMD80: bbyte = CMD_PROG;
      S_ADDR:  bbyte = addr_byte(row24, aidx_q);
      S_DATA:  bbyte = wr_data;
      S_CMD10: bbyte = CMD_CONFIRM;
      S_CMD70: bbyte = CMD_STATUS;
      default: bbyte = 8'h00;
    endcase
    case (state_q)
      S_IDLE: begin
        if (start) begin
          go      = 1'b1;
          bbyte   = CMD_PROG;
          bcle    = 1'b1;
          row_d   = row_addr;
          fail_d  = 1'b0;
          to_d    = 1'b0;
          state_d = S_CMD80;
        end
      end
      S_CMD80: begin
        if (bus_last) begin
          go      = 1'b1;
          bbyte   = addr_byte(row24, 2'd0);
          bale    = 1'b1;
          aidx_d  = '0;
          state_d = S_ADDR;
        end
      end
      S_ADDR: begin
        if (bus_last) begin
          go = 1'b1;
          if (aidx_q != 2'd3) begin
            bbyte  = addr_byte(row24, aidx_q + 2'd1);
            bale   = 1'b1;
            aidx_d = aidx_q + 2'd1;
          end else begin
            bcnt_d  = '0;
            state_d = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (bus_setup && wr_valid) bcnt_d = bcnt_q + 1'b1;
        if (bus_last) begin
          go = 1'b1;
          if (bcnt_q == BCW'(PAGE_BYTES)) begin
            bbyte   = CMD_CONFIRM;
            bcle    = 1'b1;
            state_d = S_CMD10;
          end
        end
      end
      S_CMD10: begin
        if (bus_last) begin
          tmr_d   = '0;
          state_d = S_TWB;
        end
      end
      S_TWB: begin
        if (tmr_q == TW'(TWB - 1)) begin
          tmr_d   = '0;
          state_d = S_WAIT_RB;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      S_WAIT_RB: begin
        if (rb_sync_q) begin
          go      = 1'b1;
          bbyte   = CMD_STATUS;
          bcle    = 1'b1;
          state_d = S_CMD70;
        end else if (tmr_q == TW'(BUSY_TO - 1)) begin
          to_d    = 1'b1;
          fail_d  = 1'b1;
          state_d = S_DONE;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      S_CMD70: begin
        if (bus_last) begin
          tmr_d   = '0;
          state_d = S_RD_STAT;
        end
      end
      S_RD_STAT: begin
        if (tmr_q == TW'(RE_LOW - 1)) fail_d = (io_i & 8'(1 << STATUS_FAIL_BIT)) != 8'h00;
        if (tmr_q == TW'(RE_LOW)) state_d = S_DONE;
        else tmr_d = tmr_q + 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      row_q     <= '0;
      aidx_q    <= '0;
      bcnt_q    <= '0;
      tmr_q     <= '0;
      fail_q    <= 1'b0;
      to_q      <= 1'b0;
      rb_meta_q <= 1'b0;
      rb_sync_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      row_q     <= row_d;
      aidx_q    <= aidx_d;
      bcnt_q    <= bcnt_d;
      tmr_q     <= tmr_d;
      fail_q    <= fail_d;
      to_q      <= to_d;
      rb_meta_q <= F_RB_A;
      rb_sync_q <= rb_meta_q;
    end
  end

endmodule

// File: tb/tb_nand_flash_page_writer.sv
// Directed bench for nand_flash_page_writer with a small NAND device model on the bus.
module tb_nand_flash_page_writer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [16:0] row_addr;
  logic [7:0]  wr_data;
  logic        wr_valid;
  logic        wr_ready, busy, done, fail, timeout;
  logic        F_CEN_A, F_CLE_A, F_ALE_A, F_WEN_A, F_REN_A;
  logic        F_RB_A = 1'b1;
  logic [7:0]  io_o, io_i;
  logic        io_oe;

  int          checks = 0;
  int          errors = 0;
  logic [9:0]  cap_q[$];
  int          wen_falls = 0;
  int          stall_viol = 0;
  logic        prev_stall = 1'b0;
  realtime     t_confirm = 0;
  logic [7:0]  status_val = 8'h00;
  logic        rb_hang = 1'b0;
  int          rb_low = 50;
  int          first_ready = 0;
  int          fed = 0;
  event        confirm_ev;

  always #5 clk = ~clk;

  nand_flash_page_writer #(.BUSY_TO(100)) u_dut (
    .clk(clk), .rst(rst), .start(start), .row_addr(row_addr),
    .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .busy(busy), .done(done), .fail(fail), .timeout(timeout),
    .F_CEN_A(F_CEN_A), .F_CLE_A(F_CLE_A), .F_ALE_A(F_ALE_A),
    .F_WEN_A(F_WEN_A), .F_REN_A(F_REN_A), .F_RB_A(F_RB_A),
    .io_o(io_o), .io_oe(io_oe), .io_i(io_i)
  );

  // Device model: latch on WE# rising, go busy after 0x10, drive status while RE# is low.
  assign io_i = F_REN_A ? 8'hFF : status_val;

  always @(posedge F_WEN_A) begin
    if (!F_CEN_A && io_oe) begin
      cap_q.push_back({F_CLE_A, F_ALE_A, io_o});
      if (F_CLE_A && io_o == 8'h10) begin
        t_confirm = $realtime;
        -> confirm_ev;
      end
    end
  end

  always @(negedge F_WEN_A) wen_falls++;

  always begin
    @(confirm_ev);
    F_RB_A = 1'b0;
    while (rb_hang) @(posedge clk);
    repeat (rb_low) @(posedge clk);
    F_RB_A = 1'b1;
  end

  // A clock that offered wr_ready without wr_valid must not be followed by WE# low.
  always @(negedge clk) begin
    #2;
    if (prev_stall && !F_WEN_A) stall_viol++;
    prev_stall = wr_ready && !wr_valid;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] pat(input int mode, input int idx);
    if (mode == 0) return 8'(idx);
    return 8'(idx * 7 + 3);
  endfunction

  task automatic do_start(input logic [16:0] r);
    @(negedge clk);
    row_addr = r;
    start    = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic feed(input int n, input int mode, input int budget);
    int idx = 0;
    int cyc = 0;
    first_ready = 0;
    while (idx < n && cyc < budget) begin
      @(negedge clk);
      #1;
      cyc++;
      if (wr_ready && first_ready == 0) first_ready = cyc;
      wr_valid = (mode == 0) ? 1'b1 : (((cyc / 3) % 2) == 0);
      wr_data  = pat(mode, idx);
      if (wr_valid && wr_ready) idx++;
    end
    @(negedge clk);
    #1 wr_valid = 1'b0;
    fed = idx;
  endtask

  task automatic wait_done(input int budget, output bit seen, output logic f, output logic t);
    seen = 1'b0;
    f    = 1'bx;
    t    = 1'bx;
    for (int k = 0; k < budget && !seen; k++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        f    = fail;
        t    = timeout;
      end
    end
  endtask

  task automatic check_seq(input string tag, input int base, input logic [16:0] r,
                           input int mode, input bit with_stat);
    logic [9:0] exp_q[$];
    int mism = 0;
    exp_q.push_back({2'b10, 8'h80});
    exp_q.push_back({2'b01, 8'h00});
    exp_q.push_back({2'b01, r[7:0]});
    exp_q.push_back({2'b01, r[15:8]});
    exp_q.push_back({2'b01, 7'h00, r[16]});
    for (int i = 0; i < 512; i++) exp_q.push_back({2'b00, pat(mode, i)});
    exp_q.push_back({2'b10, 8'h10});
    if (with_stat) exp_q.push_back({2'b10, 8'h70});
    chk({tag, "_len"}, cap_q.size() - base, exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      if (base + i >= cap_q.size()) mism++;
      else if (cap_q[base + i] !== exp_q[i]) mism++;
    end
    chk({tag, "_bytes"}, mism, 0);
  endtask

  initial begin
    int   base, wbase, sbase, lat;
    bit   seen;
    logic f, t;

    rst      = 1'b1;
    start    = 1'b0;
    row_addr = '0;
    wr_data  = '0;
    wr_valid = 1'b0;
    #23;
    chk("reset_outs", {F_CEN_A, F_CLE_A, F_ALE_A, F_WEN_A, F_REN_A, io_o, io_oe,
                       busy, done, fail, timeout, wr_ready},
        {1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 8'h00, 6'b000000});
    @(negedge clk) rst = 1'b0;

    // Basic program, status 0x00
    base = cap_q.size(); wbase = wen_falls;
    do_start(17'h1_2345);
    chk("start_cmd80", {busy, F_CEN_A, F_CLE_A, io_oe, F_WEN_A, io_o},
        {1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 8'h80});
    fork
      feed(512, 0, 3000);
      wait_done(4000, seen, f, t);
    join
    chk("first_data_clock", first_ready, 16);
    chk("basic_done", seen, 1);
    chk("basic_fail_to", {f, t}, 2'b00);
    chk("basic_addr", {cap_q[base + 2][7:0], cap_q[base + 3][7:0], cap_q[base + 4][7:0]}, 24'h452301);
    check_seq("basic", base, 17'h1_2345, 0, 1'b1);
    chk("basic_wen_falls", wen_falls - wbase, 519);
    @(negedge clk);
    chk("basic_idle", {busy, done, F_CEN_A}, 3'b001);

    // Backpressure, plus a start attempt mid-DATA
    base = cap_q.size(); wbase = wen_falls; sbase = stall_viol;
    do_start(17'h1_F00E);
    fork
      feed(512, 1, 6000);
      wait_done(8000, seen, f, t);
      begin
        for (int k = 0; k < 3000 && (cap_q.size() - base) < 45; k++) @(negedge clk);
        @(negedge clk);
        row_addr = 17'h0_0777;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
      end
    join
    chk("bp_fed", fed, 512);
    chk("bp_done", seen, 1);
    chk("bp_fail_to", {f, t}, 2'b00);
    check_seq("bp", base, 17'h1_F00E, 1, 1'b1);
    chk("bp_wen_falls", wen_falls - wbase, 519);
    chk("bp_stall_wen", stall_viol - sbase, 0);

    // Program failure reported by status bit 0
    status_val = 8'h01;
    base = cap_q.size();
    do_start(17'h0_0001);
    fork
      feed(512, 0, 3000);
      wait_done(4000, seen, f, t);
    join
    chk("pf_done", seen, 1);
    chk("pf_fail_to", {f, t}, 2'b10);
    check_seq("pf", base, 17'h0_0001, 0, 1'b1);

    // Timeout: R/B# never returns
    status_val = 8'h00;
    rb_hang = 1'b1;
    base = cap_q.size();
    do_start(17'h0_0002);
    chk("to_cleared_by_start", {fail, timeout}, 2'b00);
    fork
      feed(512, 0, 3000);
      wait_done(4000, seen, f, t);
    join
    lat = int'(($realtime - t_confirm) / 10.0);
    chk("to_done", seen, 1);
    chk("to_fail_to", {f, t}, 2'b11);
    chk("to_latency_ok", (lat >= 100 && lat <= 110), 1);
    check_seq("to", base, 17'h0_0002, 0, 1'b0);
    rb_hang = 1'b0;

    // Asynchronous reset in the middle of the data phase
    do_start(17'h0_5555);
    chk("rst_test_cleared", {fail, timeout}, 2'b00);
    feed(37, 0, 500);
    chk("rst_fed", fed, 37);
    #2 rst = 1'b1;
    #1;
    chk("rst_mid_outs", {F_CEN_A, F_CLE_A, F_ALE_A, F_WEN_A, F_REN_A, io_o, io_oe,
                         busy, done, fail, timeout, wr_ready},
        {1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 8'h00, 6'b000000});
    @(negedge clk) rst = 1'b0;
    repeat (60) @(negedge clk);

    // Normal program after the abort
    base = cap_q.size();
    do_start(17'h0_00FF);
    fork
      feed(512, 0, 3000);
      wait_done(4000, seen, f, t);
    join
    chk("post_rst_done", seen, 1);
    chk("post_rst_fail_to", {f, t}, 2'b00);
    check_seq("post_rst", base, 17'h0_00FF, 0, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
